// File: rtl/dac_spi_pkg.sv
// Shared constants and state encoding for the DAC serial transmitter.
package dac_spi_pkg;

   localparam int         FRAME_W    = 24;
   localparam logic [3:0] DAC_CMD_WR = 4'b1100;   // write-update (3), bit-reversed
   localparam logic [3:0] DAC_PAD    = 4'b0000;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

endpackage

// File: rtl/dac_spi_tx_tick.sv
// sclk half-period tick generator: one-clk pulse every CLK_DIV clks after clr.
module dac_sclk_tick #(
   parameter int CLK_DIV = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/dac_spi_tx.sv
// 3-wire DAC frame transmitter (sync_n/sclk/din), LSB of cmd_in shifted first.
// Define DAC_CMD_CHECK_EN to reject frames with a bad command or pad nibble.
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int FRAME_W  = dac_spi_pkg::FRAME_W,
   parameter int SYNC_GAP = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] cmd_in,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   output logic               sync_n,
   output logic               sclk,
   output logic               din,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int LAST_TICK = 2 * FRAME_W + 1;
   localparam int HW        = $clog2(LAST_TICK + SYNC_GAP + 1);
   localparam int BW        = $clog2(FRAME_W + 1);

   state_t             state, state_nxt;
   logic [FRAME_W-1:0] sr, sr_nxt;
   logic [HW-1:0]      hcnt, hcnt_nxt, k;
   logic [BW-1:0]      bcnt, bcnt_nxt;
   logic               sync_nxt, sclk_nxt, din_nxt, done_nxt, err_nxt;
   logic               armed, tick, accept, frame_ok;

   // armed keeps cmd_ready low until the first edge after reset release
   assign cmd_ready = (state == IDLE) && armed && !err;
   assign busy      = (state != IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign k         = hcnt + HW'(1);

`ifdef DAC_CMD_CHECK_EN
   assign frame_ok = (cmd_in[3:0] == DAC_CMD_WR) && (cmd_in[FRAME_W-1 -: 4] == DAC_PAD);
`else
   assign frame_ok = 1'b1;
`endif

   dac_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (busy),
      .tick (tick)
   );

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      hcnt_nxt  = hcnt;
      bcnt_nxt  = bcnt;
      sync_nxt  = sync_n;
      sclk_nxt  = sclk;
      din_nxt   = din;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (frame_ok) begin
                  sr_nxt    = cmd_in;
                  sync_nxt  = 1'b0;
                  din_nxt   = cmd_in[0];
                  hcnt_nxt  = '0;
                  bcnt_nxt  = '0;
                  state_nxt = SHIFT;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (tick) begin
               hcnt_nxt = k;
               if (k == HW'(LAST_TICK)) begin
                  sync_nxt  = 1'b1;
                  din_nxt   = 1'b0;
                  done_nxt  = 1'b1;
                  hcnt_nxt  = '0;
                  bcnt_nxt  = '0;
                  state_nxt = GAP;
               end else if (k[0]) begin
                  sclk_nxt = 1'b0;
                  bcnt_nxt = bcnt + BW'(1);
               end else begin
                  // rising edge: advance din unless all bits have been sampled
                  sclk_nxt = 1'b1;
                  if (bcnt != BW'(FRAME_W)) begin
                     sr_nxt  = sr >> 1;
                     din_nxt = sr[1];
                  end
               end
            end
         end
         GAP: begin
            if (tick) begin
               hcnt_nxt = k;
               if (k == HW'(SYNC_GAP)) begin
                  hcnt_nxt  = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         sr     <= '0;
         hcnt   <= '0;
         bcnt   <= '0;
         sync_n <= 1'b1;
         sclk   <= 1'b1;
         din    <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         armed  <= 1'b0;
      end else begin
         state  <= state_nxt;
         sr     <= sr_nxt;
         hcnt   <= hcnt_nxt;
         bcnt   <= bcnt_nxt;
         sync_n <= sync_nxt;
         sclk   <= sclk_nxt;
         din    <= din_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
         armed  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: CLK_DIV=4 and CLK_DIV=2 instances on one clock.
module tb_dac_spi_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [23:0] a_cmd = '0, b_cmd = '0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, a_sync_n, a_sclk, a_din, a_busy, a_done, a_err;
   logic        b_ready, b_sync_n, b_sclk, b_din, b_busy, b_done, b_err;

   dac_spi_tx #(.CLK_DIV(4)) u_a (
      .clk(clk), .rst(rst), .cmd_in(a_cmd), .cmd_valid(a_valid), .cmd_ready(a_ready),
      .sync_n(a_sync_n), .sclk(a_sclk), .din(a_din), .busy(a_busy), .done(a_done), .err(a_err)
   );

   dac_spi_tx #(.CLK_DIV(2)) u_b (
      .clk(clk), .rst(rst), .cmd_in(b_cmd), .cmd_valid(b_valid), .cmd_ready(b_ready),
      .sync_n(b_sync_n), .sclk(b_sclk), .din(b_din), .busy(b_busy), .done(b_done), .err(b_err)
   );

   bit   sel = 1'b0;
   logic s_ready, s_sync_n, s_sclk, s_din, s_done;
   assign s_ready  = sel ? b_ready  : a_ready;
   assign s_sync_n = sel ? b_sync_n : a_sync_n;
   assign s_sclk   = sel ? b_sclk   : a_sclk;
   assign s_din    = sel ? b_din    : a_din;
   assign s_done   = sel ? b_done   : a_done;

   int checks = 0;
   int errors = 0;

   function automatic logic [23:0] rev24(input logic [23:0] x);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = x[23-i];
      return r;
   endfunction

   task automatic drive(input bit s, input logic [23:0] c, input logic v);
      if (s) begin b_cmd = c; b_valid = v; end
      else   begin a_cmd = c; a_valid = v; end
   endtask

   // One frame: accept, then walk edge by edge until cmd_ready returns.
   task automatic xfer(input bit s, input logic [23:0] cmd, input bit hold, input logic [23:0] after,
                       output int t_done, output int t_rdy, output int ndone,
                       output logic [23:0] cap, output int falls, output int viol, output int hi);
      int   w;
      logic ps;
      sel = s; #1;
      t_done = -1; t_rdy = -1; ndone = 0; cap = '0; falls = 0; viol = 0; hi = 0;
      w = 0;
      while (!s_ready && w < 300) begin @(posedge clk); #1; w++; end
      drive(s, cmd, 1'b1);
      @(posedge clk); #1;
      drive(s, after, hold);
      ps = s_sclk;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (s_done) begin ndone++; if (t_done < 0) t_done = n; end
         if (ps && !s_sclk) begin cap = {cap[22:0], s_din}; falls++; end
         if (s_sync_n && (s_sclk != ps)) viol++;
         if (s_sync_n) hi++;
         ps = s_sclk;
         if (s_ready) begin t_rdy = n; break; end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      checks++; if ({a_sync_n, a_sclk, a_din} !== 3'b110) begin errors++;
         $display("FAIL reset_bus got %b exp 110", {a_sync_n, a_sclk, a_din}); end
      checks++; if ({a_busy, a_done, a_err, a_ready} !== 4'b0000) begin errors++;
         $display("FAIL reset_ctl got %b exp 0000", {a_busy, a_done, a_err, a_ready}); end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++;
         $display("FAIL reset_ready got %b%b exp 11", a_ready, b_ready); end
   endtask

   task automatic test_single();
      int td, tr, nd, fl, vi, hi;
      logic [23:0] cap;
      // cmd_in is scrambled right after accept; the latched value must still go out
      xfer(0, rev24(24'h3A5C30), 0, ~rev24(24'h3A5C30), td, tr, nd, cap, fl, vi, hi);
      checks++; if (cap !== 24'h3A5C30) begin errors++; $display("FAIL single_data got %h exp 3a5c30", cap); end
      checks++; if (fl != 24) begin errors++; $display("FAIL single_falls got %0d exp 24", fl); end
      checks++; if (td != 196 || nd != 1) begin errors++;
         $display("FAIL single_done got t=%0d n=%0d exp t=196 n=1", td, nd); end
      checks++; if (tr != 204) begin errors++; $display("FAIL single_ready got %0d exp 204", tr); end
      checks++; if (vi != 0) begin errors++; $display("FAIL single_idle_sclk got %0d exp 0", vi); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] frm [3];
      logic [23:0] cap;
      int td, tr, nd, fl, vi, hi;
      frm[0] = 24'h300000; frm[1] = 24'h3FFFF0; frm[2] = 24'h380010;
      for (int i = 0; i < 3; i++) begin
         xfer(0, rev24(frm[i]), (i < 2), (i < 2) ? rev24(frm[(i + 1) % 3]) : 24'h0,
              td, tr, nd, cap, fl, vi, hi);
         checks++; if (cap !== frm[i] || fl != 24) begin errors++;
            $display("FAIL b2b_data[%0d] got %h/%0d exp %h/24", i, cap, fl, frm[i]); end
         checks++; if (tr != 204 || td != 196) begin errors++;
            $display("FAIL b2b_time[%0d] got rdy=%0d done=%0d exp 204/196", i, tr, td); end
         checks++; if (hi < 8 || vi != 0) begin errors++;
            $display("FAIL b2b_gap[%0d] got hi=%0d viol=%0d exp >=8/0", i, hi, vi); end
      end
   endtask

   task automatic test_reset_mid();
      int nd, td, tr, fl, vi, hi;
      logic [23:0] cap;
      sel = 0; #1;
      drive(0, rev24(24'h3A5C30), 1'b1);
      @(posedge clk); #1;
      drive(0, 24'h0, 1'b0);
      nd = 0;
      for (int n = 1; n <= 60; n++) begin @(posedge clk); #1; if (a_done) nd++; end
      checks++; if ({a_sync_n, a_sclk} !== 2'b00) begin errors++;
         $display("FAIL mid_running got %b exp 00", {a_sync_n, a_sclk}); end
      rst = 1'b0;
      #1;
      checks++; if ({a_sync_n, a_sclk, a_din, a_busy, a_ready} !== 5'b11000) begin errors++;
         $display("FAIL mid_reset_bus got %b exp 11000", {a_sync_n, a_sclk, a_din, a_busy, a_ready}); end
      @(negedge clk); @(negedge clk) rst = 1'b1;
      for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (a_done) nd++; end
      checks++; if (nd != 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", nd); end
      xfer(0, rev24(24'h312340), 0, 24'h0, td, tr, nd, cap, fl, vi, hi);
      checks++; if (cap !== 24'h312340 || fl != 24 || td != 196) begin errors++;
         $display("FAIL mid_next got %h/%0d/%0d exp 312340/24/196", cap, fl, td); end
   endtask

   task automatic test_clkdiv2();
      int td, tr, nd, fl, vi, hi;
      logic [23:0] cap;
      xfer(1, rev24(24'h35A0F0), 0, 24'hFFFFFF, td, tr, nd, cap, fl, vi, hi);
      checks++; if (cap !== 24'h35A0F0 || fl != 24) begin errors++;
         $display("FAIL div2_data got %h/%0d exp 35a0f0/24", cap, fl); end
      checks++; if (td != 98 || tr != 102 || nd != 1) begin errors++;
         $display("FAIL div2_time got done=%0d rdy=%0d n=%0d exp 98/102/1", td, tr, nd); end
   endtask

   task automatic test_cmd_check();
      logic [23:0] bad, cap;
      int td, tr, nd, fl, vi, hi;
      bad = rev24(24'h3A5C30);
      bad[3:0] = 4'b0100;
`ifdef DAC_CMD_CHECK_EN
      sel = 0; #1;
      drive(0, bad, 1'b1);
      @(posedge clk); #1;
      drive(0, bad, 1'b0);
      checks++; if ({a_err, a_sync_n, a_busy, a_ready} !== 4'b1100) begin errors++;
         $display("FAIL chk_reject got %b exp 1100", {a_err, a_sync_n, a_busy, a_ready}); end
      @(posedge clk); #1;
      checks++; if ({a_err, a_sync_n, a_ready} !== 3'b011) begin errors++;
         $display("FAIL chk_recover got %b exp 011", {a_err, a_sync_n, a_ready}); end
      xfer(0, rev24(24'h3A5C30), 0, 24'h0, td, tr, nd, cap, fl, vi, hi);
      checks++; if (cap !== 24'h3A5C30 || td != 196) begin errors++;
         $display("FAIL chk_valid got %h/%0d exp 3a5c30/196", cap, td); end
`else
      xfer(0, bad, 0, 24'h0, td, tr, nd, cap, fl, vi, hi);
      checks++; if (cap !== 24'h2A5C30 || nd != 1) begin errors++;
         $display("FAIL nochk_send got %h/%0d exp 2a5c30/1", cap, nd); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL nochk_err got %b exp 0", a_err); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_clkdiv2();
      test_cmd_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
